rx_frame_ctrl: RTL

RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

---
 rtl/rx_frame_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rx_frame_ctrl.sv
// rtl/rx_frame_ctrl.sv - UART byte-stream framer: sync, length, payload, XOR checksum, drain
module rx_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 16,
  parameter int         TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] word,
  input  logic       recieve_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = $clog2(MAX_LEN);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CSUM, DRAIN} state_t;

  state_t        state;
  logic          rr_q;
  logic [7:0]    buf_mem [MAX_LEN];
  logic [LW-1:0] len;
  logic [LW-1:0] wr_ptr;
  logic [LW-1:0] rd_ptr;
  logic [7:0]    xor_acc;
  logic [TW-1:0] tcnt;

  logic          byte_ev;
  logic          timed_out;
  logic          len_bad;
  logic [LW-1:0] last_idx;
  logic          abort;
  logic [1:0]    abort_code;

  assign byte_ev   = recieve_ready & ~rr_q;
  assign timed_out = (tcnt == TW'(TIMEOUT - 1));
  assign len_bad   = (word == 8'd0) || (int'(word) > MAX_LEN);
  assign last_idx  = len - LW'(1);

  assign busy      = (state != IDLE);
  assign out_valid = (state == DRAIN);
  assign out_last  = (state == DRAIN) && (rd_ptr == last_idx);
  assign out_data  = (state == DRAIN) ? buf_mem[rd_ptr[AW-1:0]] : 8'h00;

  // Everything that throws the frame away and returns to IDLE with an error
  always_comb begin
    abort      = 1'b0;
    abort_code = 2'd0;
    case (state)
      LEN: begin
        if (byte_ev) begin
          abort = len_bad;
        end else if (timed_out) begin
          abort      = 1'b1;
          abort_code = 2'd2;
        end
      end
      PAYLOAD: begin
        if (!byte_ev && timed_out) begin
          abort      = 1'b1;
          abort_code = 2'd2;
        end
      end
      CSUM: begin
        if (byte_ev) begin
          if (word != xor_acc) begin
            abort      = 1'b1;
            abort_code = 2'd1;
          end
        end else if (timed_out) begin
          abort      = 1'b1;
          abort_code = 2'd2;
        end
      end
      default: begin
        abort      = 1'b0;
        abort_code = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == PAYLOAD && byte_ev) begin
      buf_mem[wr_ptr[AW-1:0]] <= word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_q      <= 1'b0;
      len       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      xor_acc   <= 8'h00;
      tcnt      <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      rr_q      <= recieve_ready;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (abort) begin
        frame_err <= 1'b1;
        err_code  <= abort_code;
        state     <= IDLE;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        tcnt      <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (byte_ev && word == SYNC_BYTE) begin
              state  <= LEN;
              wr_ptr <= '0;
              rd_ptr <= '0;
              tcnt   <= '0;
            end
          end
          LEN: begin
            if (byte_ev) begin
              len     <= word[LW-1:0];
              xor_acc <= word;
              tcnt    <= '0;
              state   <= PAYLOAD;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          PAYLOAD: begin
            if (byte_ev) begin
              xor_acc <= xor_acc ^ word;
              wr_ptr  <= wr_ptr + 1'b1;
              tcnt    <= '0;
              if (wr_ptr == last_idx) begin
                state <= CSUM;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          CSUM: begin
            if (byte_ev) begin
              frame_ok <= 1'b1;
              state    <= DRAIN;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          DRAIN: begin
            // Incoming bytes cannot be stored while draining; report and keep going
            if (byte_ev) begin
              frame_err <= 1'b1;
              err_code  <= 2'd3;
            end
            if (out_ready) begin
              rd_ptr <= rd_ptr + 1'b1;
              if (rd_ptr == last_idx) begin
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
